// File: rtl/mem_pkg.sv
// Shared definitions for the memory queue controller.
//   ADDR_WIDTH / DATA_WIDTH / DEPTH : geometry of the 1024x8 MEMORY block
//   op_t : which memory operation owns the shared address port
//   rd_t : which consumer a read strobe is directed to
package mem_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 1024;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  typedef enum logic {
    RD_A = 1'b0,
    RD_B = 1'b1
  } rd_t;

endpackage

// File: rtl/mem_queue_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant register.
//   clk, rst : clock and asynchronous active-high reset
//   req[1:0] : request lines, bit 0 and bit 1
//   en       : the grant is actually consumed this cycle; the last-grant
//              register only advances when en is high
//   gnt[1:0] : one-hot (or zero) combinational grant
// A lone requester always wins and leaves the last-grant register alone;
// only a genuine conflict flips it. RESET_LAST names the requester treated
// as the previous winner, so the other one wins the first conflict.
module rr_arbiter2 #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt = last_q ? 2'b01 : 2'b10;
        if (en) begin
          last_d = ~last_q;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= RESET_LAST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_queue_ctrl.sv
// Circular-queue controller in front of a single-address-port MEMORY.
//   Clock, Reset          : rising-edge clock, asynchronous active-high reset
//   iDataValid/iData      : producer byte stream; accepted when oReady is high
//   oReady                : combinational accept for the current cycle
//   iReqA/iReqB           : consumer read requests (held until served)
//   oWriteEnable/oAddress/oDataIn/oReadtoa/oReadtob : registered MEMORY controls
//   oValidA/oValidB       : read strobes delayed one cycle, aligned with
//                           MEMORY's oDataOuta/oDataOutb
//   oFull/oEmpty/oCount   : registered occupancy
// Exactly one memory operation is granted per cycle. Write-vs-read and
// A-vs-B conflicts are each resolved by a round-robin arbiter.
// DEPTH must equal 2**ADDR_WIDTH so the pointers wrap by plain overflow.
module mem_queue_ctrl #(
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
  parameter int DEPTH      = mem_pkg::DEPTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iDataValid,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oReady,
  input  logic                  iReqA,
  input  logic                  iReqB,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  output logic                  oReadtoa,
  output logic                  oReadtob,
  output logic                  oValidA,
  output logic                  oValidB,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [ADDR_WIDTH:0]   oCount
);

  import mem_pkg::*;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  we_q, we_d;
  logic                  rda_q, rda_d;
  logic                  rdb_q, rdb_d;
  logic                  vlda_q, vldb_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic       wr_pend;
  logic       rd_pend;
  logic [1:0] op_gnt;
  logic [1:0] rd_gnt;
  logic       do_wr;
  logic       do_rd;

  // Pending conditions use the registered flags so a grant can never
  // overfill or underflow the queue.
  assign wr_pend = iDataValid && !full_q;
  assign rd_pend = (iReqA || iReqB) && !empty_q;

  // Requester 0 is the write side; READ counts as the previous winner
  // so the first write/read conflict goes to the write.
  rr_arbiter2 #(
    .RESET_LAST(1'(OP_READ))
  ) u_op_arb (
    .clk (Clock),
    .rst (Reset),
    .req ({rd_pend, wr_pend}),
    .en  (1'b1),
    .gnt (op_gnt)
  );

  assign do_wr = op_gnt[0];
  assign do_rd = op_gnt[1];

  // Requester 0 is consumer A. The A/B history only moves when a read
  // is actually performed, so a consumer starved by a write keeps its turn.
  rr_arbiter2 #(
    .RESET_LAST(1'(RD_B))
  ) u_rd_arb (
    .clk (Clock),
    .rst (Reset),
    .req ({iReqB, iReqA}),
    .en  (do_rd),
    .gnt (rd_gnt)
  );

  // oReady equals the write grant: wr_pend && (!rd_pend || last_op==READ).
  assign oReady = do_wr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    rda_d    = 1'b0;
    rdb_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    if (do_wr) begin
      we_d     = 1'b1;
      addr_d   = wr_ptr_q;
      din_d    = iData;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (do_rd) begin
      rda_d    = rd_gnt[0];
      rdb_d    = rd_gnt[1];
      addr_d   = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      we_q     <= 1'b0;
      rda_q    <= 1'b0;
      rdb_q    <= 1'b0;
      vlda_q   <= 1'b0;
      vldb_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      we_q     <= we_d;
      rda_q    <= rda_d;
      rdb_q    <= rdb_d;
      // MEMORY answers one cycle after the strobe.
      vlda_q   <= rda_q;
      vldb_q   <= rdb_q;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign oWriteEnable = we_q;
  assign oAddress     = addr_q;
  assign oDataIn      = din_q;
  assign oReadtoa     = rda_q;
  assign oReadtob     = rdb_q;
  assign oValidA      = vlda_q;
  assign oValidB      = vldb_q;
  assign oFull        = full_q;
  assign oEmpty       = empty_q;
  assign oCount       = count_q;

endmodule

// File: tb/tb_mem_queue_ctrl.sv
// Bench for mem_queue_ctrl: directed and random steps checked against a
// queue-based model of the controller plus a model of the 1024x8 MEMORY.
module tb_mem_queue_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          Clock;
  logic          Reset;
  logic          iDataValid;
  logic [DW-1:0] iData;
  logic          oReady;
  logic          iReqA;
  logic          iReqB;
  logic          oWriteEnable;
  logic [AW-1:0] oAddress;
  logic [DW-1:0] oDataIn;
  logic          oReadtoa;
  logic          oReadtob;
  logic          oValidA;
  logic          oValidB;
  logic          oFull;
  logic          oEmpty;
  logic [AW:0]   oCount;

  mem_queue_ctrl dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iDataValid   (iDataValid),
    .iData        (iData),
    .oReady       (oReady),
    .iReqA        (iReqA),
    .iReqB        (iReqB),
    .oWriteEnable (oWriteEnable),
    .oAddress     (oAddress),
    .oDataIn      (oDataIn),
    .oReadtoa     (oReadtoa),
    .oReadtob     (oReadtob),
    .oValidA      (oValidA),
    .oValidB      (oValidB),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oCount       (oCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // MEMORY block model: synchronous write, one-cycle read per port.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;
  always @(posedge Clock) begin
    if (oWriteEnable) mem[oAddress] <= oDataIn;
    if (oReadtoa) douta <= mem[oAddress];
    if (oReadtob) doutb <= mem[oAddress];
  end

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] pend_a[$];
  logic [DW-1:0] pend_b[$];
  logic [AW-1:0] m_wptr;
  logic [AW-1:0] m_rptr;
  logic          m_last_was_read;
  logic          m_last_was_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          m_vlda;
  logic          m_vldb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    pend_a.delete();
    pend_b.delete();
    m_wptr          = '0;
    m_rptr          = '0;
    m_last_was_read = 1'b1;
    m_last_was_b    = 1'b1;
    m_addr          = '0;
    m_din           = '0;
    m_vlda          = 1'b0;
    m_vldb          = 1'b0;
  endtask

  task automatic check_occupancy(input string tag);
    chk({tag, "_count"}, 32'(oCount), 32'(m_q.size()));
    chk({tag, "_full"},  32'(oFull),  32'(m_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(oEmpty), 32'(m_q.size() == 0));
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    iDataValid = 1'b0;
    iData      = '0;
    iReqA      = 1'b0;
    iReqB      = 1'b0;
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_we",    32'(oWriteEnable), 0);
    chk("rst_rda",   32'(oReadtoa), 0);
    chk("rst_rdb",   32'(oReadtob), 0);
    chk("rst_vlda",  32'(oValidA), 0);
    chk("rst_vldb",  32'(oValidB), 0);
    chk("rst_addr",  32'(oAddress), 0);
    chk("rst_din",   32'(oDataIn), 0);
    check_occupancy("rst");
  endtask

  // One clock cycle: apply inputs, check the combinational accept, then
  // check everything registered at the following edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ra, input logic rb);
    logic wp, rp, do_w, do_r, sel_b;
    logic [DW-1:0] word;
    iDataValid = v;
    iData      = d;
    iReqA      = ra;
    iReqB      = rb;
    wp   = v && (m_q.size() < DEPTH);
    rp   = (ra || rb) && (m_q.size() > 0);
    do_w = wp && (!rp || m_last_was_read);
    do_r = rp && !do_w;
    if (wp && rp) m_last_was_read = do_r;
    sel_b = rb && !(ra && m_last_was_b);
    if (do_r && ra && rb) m_last_was_b = sel_b;
    #1;
    chk("ready", 32'(oReady), 32'(do_w));
    if (do_w) begin
      m_q.push_back(d);
      m_addr = m_wptr;
      m_din  = d;
      m_wptr = m_wptr + 1'b1;
    end else if (do_r) begin
      word   = m_q.pop_front();
      m_addr = m_rptr;
      m_rptr = m_rptr + 1'b1;
      if (sel_b) pend_b.push_back(word);
      else       pend_a.push_back(word);
    end
    @(posedge Clock);
    #1;
    chk("we",   32'(oWriteEnable), 32'(do_w));
    chk("rda",  32'(oReadtoa), 32'(do_r && !sel_b));
    chk("rdb",  32'(oReadtob), 32'(do_r && sel_b));
    chk("addr", 32'(oAddress), 32'(m_addr));
    chk("din",  32'(oDataIn), 32'(m_din));
    chk("vlda", 32'(oValidA), 32'(m_vlda));
    chk("vldb", 32'(oValidB), 32'(m_vldb));
    if (m_vlda && pend_a.size() > 0) chk("douta", 32'(douta), 32'(pend_a.pop_front()));
    if (m_vldb && pend_b.size() > 0) chk("doutb", 32'(doutb), 32'(pend_b.pop_front()));
    check_occupancy("step");
    m_vlda = do_r && !sel_b;
    m_vldb = do_r && sel_b;
  endtask

  initial begin
    Reset      = 1'b1;
    iDataValid = 1'b0;
    iData      = '0;
    iReqA      = 1'b0;
    iReqB      = 1'b0;
    model_reset();

    // Three writes then three reads by A.
    do_reset();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t1_count3", 32'(oCount), 3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t2_empty", 32'(oEmpty), 1);

    // Streaming write and read against one stored word.
    do_reset();
    step(1, 8'h5C, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 1, 0);
    step(0, 8'h00, 0, 0);

    // Both consumers requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Fill to capacity, reject the extra byte, free one slot, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0);
    chk("full_flag", 32'(oFull), 1);
    step(1, 8'hEE, 0, 0);
    chk("full_hold", 32'(oCount), DEPTH);
    step(0, 8'h00, 1, 0);
    step(1, 8'h5A, 0, 0);
    chk("wrap_addr", 32'(oAddress), 0);
    chk("wrap_we",   32'(oWriteEnable), 1);
    while (m_q.size() > 0) step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom));
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Reset asserted while a B read is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(0, 8'h00, 0, 1);
    chk("pre_rdb", 32'(oReadtob), 1);
    Reset = 1'b1;
    #1;
    chk("async_vldb",  32'(oValidB), 0);
    chk("async_rdb",   32'(oReadtob), 0);
    chk("async_count", 32'(oCount), 0);
    chk("async_empty", 32'(oEmpty), 1);
    do_reset();
    step(0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
